ro_buffer: RTL and testbench
============================

# ro_buffer

Reorder buffer for the out-of-order core. It allocates an entry per issued instruction and collects results from the common data bus (CDB). It commits completed entries in program order to the register file through the `dest`/`rd`/`value` commit port. On a mispredicted branch it broadcasts a flush on the ROB bus and redirects fetch. It sits between the issuer/CDB and the register file.

## Interface
- `DEPTH`, default 15: number of entries. Entry ids run 1..DEPTH; id 0 is reserved and means "no producer / ready".
- `ID_W`, default 4: width of an entry id; must satisfy 2^ID_W > DEPTH.
- `clk  in  1  clock`
- `rst  in  1  reset, synchronous, active-high`
- `rdy  in  1  global enable; when 0 all state holds`
- `issue_valid  in  1  allocate one entry this cycle`
- `issue_rd  in  5  destination register; 0 means no register write`
- `issue_is_branch  in  1  entry is a branch`
- `dest_to_issuer  out  ID_W  id the next allocation will receive (tail)`
- `full_to_issuer  out  1  no free entry`
- `cdb_valid  in  1  result broadcast valid`
- `cdb_id  in  ID_W  producing entry id`
- `cdb_value  in  32  result; for branches, the correct next PC`
- `cdb_mispredict  in  1  branch resolved opposite to its prediction`
- `query_j_id, query_k_id  in  ID_W  operand producer ids from issuer`
- `ready_j, ready_k  out  1  queried result available`
- `value_j, value_k  out  32  queried result (0 when not ready)`
- `dest_to_reg_file  out  ID_W  committing entry id, 0 when idle`
- `rd_to_reg_file  out  5  committing rd, 0 when idle`
- `value_to_reg_file  out  32  committing value`
- `reset_to_rob_bus  out  1  flush pulse`
- `pc_to_fetcher  out  32  redirect target, valid with flush`

## Operation
- Circular buffer: head (oldest) and tail (next free) pointers, plus a count. Pointers advance 1→2→…→DEPTH→1; they never take value 0.
- Per entry: busy, ready, rd, is_branch, mispredict, value.
- Issue (`issue_valid && !full_to_issuer`): write the entry at tail with busy=1 and ready=0; tail advances; count+1. `issue_valid` while full is ignored.
- CDB (`cdb_valid`, busy entry `cdb_id`): set ready=1 and latch value and mispredict. A CDB hit on a non-busy id is ignored.
- Commit: at most one per cycle, when the head entry is busy and ready. Clear the entry, advance head, count−1.
  - Non-mispredicted entry: drive `dest_to_reg_file`=head id, `rd_to_reg_file`=rd, `value_to_reg_file`=value. A branch drives rd=0.
  - Mispredicted branch: drive rd=0 and dest=0, `reset_to_rob_bus`=1, `pc_to_fetcher`=value.
- Flush: on the edge after `reset_to_rob_bus`=1, all busy bits clear, head=tail=1, count=0. Issue and CDB events in that cycle are discarded.
- Query: id 0 returns ready=1, value=0. Otherwise ready=1 with the stored value if the entry is ready, else ready=0 and value=0.
- `full_to_issuer` = (count==DEPTH), computed from registered count. Issue is blocked when full even if a commit happens in the same cycle.

## Timing
- Reset: head=tail=1, count=0, all entries clear. Outputs: `dest_to_issuer`=1, `full_to_issuer`=0, commit outputs 0, `reset_to_rob_bus`=0, `pc_to_fetcher`=0.
- Commit, flush and redirect outputs are registered. They are valid for exactly one cycle after the commit edge and are otherwise 0.
- Minimum latency: issue at edge E0, CDB at edge E1, commit outputs valid after edge E2.
- Query outputs are combinational from state plus the same-cycle CDB (see Configuration).
- Simultaneous issue, CDB and commit on different entries are all honoured in one edge.
- `rst` has priority over flush. Flush has priority over issue and CDB.
- `rdy`=0: no state change. Commit and flush outputs go to 0 at the next edge.

## Configuration
- `RO_BUFFER_BYPASS_EN` defined: a query whose id equals `cdb_id` while `cdb_valid` returns ready=1 and `cdb_value` combinationally, in the same cycle.
- Not defined: queries see only stored ready bits. The result becomes visible the cycle after the CDB write.

## Test plan
- Reset, then issue rd=5 (id 1), CDB id 1 value 0x1234 -> after 2 edges, dest=1, rd=5, value=0x1234 for one cycle; then dest=0, rd=0.
- Issue 15 entries -> `full_to_issuer`=1; a 16th issue is ignored; commit one, then issue -> new id=1 (wrap), full again.
- Issue ids 1 and 2; CDB id 2 first, then id 1 -> commits in order: id 1, then id 2, on consecutive cycles.
- Issue branch (id 1), rd=3 (id 2); CDB id 1 mispredict value 0x80 -> flush=1, `pc_to_fetcher`=0x80, no reg write; next cycle `dest_to_issuer`=1, count=0.
- Query id 4 in the same cycle as CDB id 4 value 0x55 -> with BYPASS_EN: ready=1, value=0x55; without it: ready=0, then ready=1 next cycle.
- Hold `rdy`=0 with a ready head -> no commit; raise `rdy` -> commit on the next edge. Assert `rst` mid-flush -> reset state.

Source files
------------

// File: rtl/ro_buffer.sv
// Reorder buffer: allocates entries in program order, collects CDB results, commits in order.
// Define RO_BUFFER_BYPASS_EN to forward a same-cycle CDB result to the operand queries.
module ro_buffer #(
  parameter int DEPTH = 15,
  parameter int ID_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            issue_is_branch,
  output logic [ID_W-1:0] dest_to_issuer,
  output logic            full_to_issuer,
  input  logic            cdb_valid,
  input  logic [ID_W-1:0] cdb_id,
  input  logic [31:0]     cdb_value,
  input  logic            cdb_mispredict,
  input  logic [ID_W-1:0] query_j_id,
  input  logic [ID_W-1:0] query_k_id,
  output logic            ready_j,
  output logic            ready_k,
  output logic [31:0]     value_j,
  output logic [31:0]     value_k,
  output logic [ID_W-1:0] dest_to_reg_file,
  output logic [4:0]      rd_to_reg_file,
  output logic [31:0]     value_to_reg_file,
  output logic            reset_to_rob_bus,
  output logic [31:0]     pc_to_fetcher
);
  localparam logic [ID_W-1:0] DEPTH_ID = ID_W'(DEPTH);
  localparam logic [ID_W-1:0] ONE_ID   = ID_W'(1);

  logic [ID_W-1:0] head_q, tail_q, count_q;
  logic            busy_q   [1:DEPTH];
  logic            ready_q  [1:DEPTH];
  logic            branch_q [1:DEPTH];
  logic            mis_q    [1:DEPTH];
  logic [4:0]      rd_q     [1:DEPTH];
  logic [31:0]     val_q    [1:DEPTH];

  logic [ID_W-1:0] cm_dest_q;
  logic [4:0]      cm_rd_q;
  logic [31:0]     cm_value_q;
  logic            flush_q;
  logic [31:0]     pc_q;

  logic do_issue, cdb_hit, do_commit, head_mis;

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    return (p == DEPTH_ID) ? ONE_ID : p + ONE_ID;
  endfunction

  // Returns {ready, value} for an operand producer id.
  function automatic logic [32:0] lookup(input logic [ID_W-1:0] id);
    logic [32:0] r;
    r = 33'd0;
    if (id == '0) r = {1'b1, 32'd0};
`ifdef RO_BUFFER_BYPASS_EN
    else if (cdb_valid && (cdb_id == id)) r = {1'b1, cdb_value};
`endif
    else if ((id <= DEPTH_ID) && ready_q[id]) r = {1'b1, val_q[id]};
    return r;
  endfunction

  assign dest_to_issuer    = tail_q;
  assign full_to_issuer    = (count_q == DEPTH_ID);
  assign dest_to_reg_file  = cm_dest_q;
  assign rd_to_reg_file    = cm_rd_q;
  assign value_to_reg_file = cm_value_q;
  assign reset_to_rob_bus  = flush_q;
  assign pc_to_fetcher     = pc_q;

  assign do_issue  = issue_valid && !full_to_issuer;
  assign cdb_hit   = cdb_valid && (cdb_id != '0) && (cdb_id <= DEPTH_ID) && busy_q[cdb_id];
  // Nothing else retires in the cycle the flush is being broadcast.
  assign do_commit = busy_q[head_q] && ready_q[head_q] && !flush_q;
  assign head_mis  = branch_q[head_q] && mis_q[head_q];

  always_comb begin
    {ready_j, value_j} = lookup(query_j_id);
    {ready_k, value_k} = lookup(query_k_id);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= ONE_ID;
      tail_q     <= ONE_ID;
      count_q    <= '0;
      cm_dest_q  <= '0;
      cm_rd_q    <= '0;
      cm_value_q <= '0;
      flush_q    <= 1'b0;
      pc_q       <= '0;
      for (int i = 1; i <= DEPTH; i++) begin
        busy_q[i]   <= 1'b0;
        ready_q[i]  <= 1'b0;
        branch_q[i] <= 1'b0;
        mis_q[i]    <= 1'b0;
        rd_q[i]     <= '0;
        val_q[i]    <= '0;
      end
    end else if (!rdy) begin
      cm_dest_q  <= '0;
      cm_rd_q    <= '0;
      cm_value_q <= '0;
      flush_q    <= 1'b0;
      pc_q       <= '0;
    end else begin
      cm_dest_q  <= '0;
      cm_rd_q    <= '0;
      cm_value_q <= '0;
      flush_q    <= 1'b0;
      pc_q       <= '0;
      if (flush_q) begin
        head_q  <= ONE_ID;
        tail_q  <= ONE_ID;
        count_q <= '0;
        for (int i = 1; i <= DEPTH; i++) begin
          busy_q[i]  <= 1'b0;
          ready_q[i] <= 1'b0;
          mis_q[i]   <= 1'b0;
        end
      end else begin
        if (do_issue) begin
          busy_q[tail_q]   <= 1'b1;
          ready_q[tail_q]  <= 1'b0;
          branch_q[tail_q] <= issue_is_branch;
          mis_q[tail_q]    <= 1'b0;
          rd_q[tail_q]     <= issue_rd;
          val_q[tail_q]    <= '0;
          tail_q           <= ptr_inc(tail_q);
        end
        if (cdb_hit) begin
          ready_q[cdb_id] <= 1'b1;
          val_q[cdb_id]   <= cdb_value;
          mis_q[cdb_id]   <= cdb_mispredict;
        end
        // Commit is last so its clear wins over a same-edge CDB rewrite of the head.
        if (do_commit) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          mis_q[head_q]   <= 1'b0;
          head_q          <= ptr_inc(head_q);
          if (head_mis) begin
            flush_q <= 1'b1;
            pc_q    <= val_q[head_q];
          end else begin
            cm_dest_q  <= head_q;
            cm_rd_q    <= branch_q[head_q] ? 5'd0 : rd_q[head_q];
            cm_value_q <= val_q[head_q];
          end
        end
        count_q <= count_q + ID_W'(do_issue) - ID_W'(do_commit);
      end
    end
  end
endmodule

// File: tb/tb_ro_buffer.sv
// Directed bench for ro_buffer: commit stream checked against an expected queue by a monitor.
module tb_ro_buffer;
  localparam int DEPTH = 15;
  localparam int ID_W  = 4;
  localparam int W     = 1 + 32 + 32 + ID_W + 5;

  logic            clk = 1'b0;
  logic            rst, rdy;
  logic            issue_valid, issue_is_branch;
  logic [4:0]      issue_rd;
  logic [ID_W-1:0] dest_to_issuer;
  logic            full_to_issuer;
  logic            cdb_valid, cdb_mispredict;
  logic [ID_W-1:0] cdb_id;
  logic [31:0]     cdb_value;
  logic [ID_W-1:0] query_j_id, query_k_id;
  logic            ready_j, ready_k;
  logic [31:0]     value_j, value_k;
  logic [ID_W-1:0] dest_to_reg_file;
  logic [4:0]      rd_to_reg_file;
  logic [31:0]     value_to_reg_file;
  logic            reset_to_rob_bus;
  logic [31:0]     pc_to_fetcher;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  ro_buffer #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
    .dest_to_issuer(dest_to_issuer), .full_to_issuer(full_to_issuer),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value), .cdb_mispredict(cdb_mispredict),
    .query_j_id(query_j_id), .query_k_id(query_k_id),
    .ready_j(ready_j), .ready_k(ready_k), .value_j(value_j), .value_k(value_k),
    .dest_to_reg_file(dest_to_reg_file), .rd_to_reg_file(rd_to_reg_file),
    .value_to_reg_file(value_to_reg_file), .reset_to_rob_bus(reset_to_rob_bus),
    .pc_to_fetcher(pc_to_fetcher)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input logic fl, input logic [31:0] pc, input logic [31:0] v,
                                        input logic [ID_W-1:0] d, input logic [4:0] r);
    return {fl, pc, v, d, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0; issue_is_branch = 1'b0;
    cdb_valid = 1'b0; cdb_id = '0; cdb_value = '0; cdb_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rdy = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic br);
    idle();
    issue_valid = 1'b1; issue_rd = rd; issue_is_branch = br;
    tick();
    idle();
  endtask

  task automatic cdb(input logic [ID_W-1:0] id, input logic [31:0] v, input logic mis);
    idle();
    cdb_valid = 1'b1; cdb_id = id; cdb_value = v; cdb_mispredict = mis;
    tick();
    idle();
  endtask

  // Scoreboard monitor: any non-idle commit/flush output is one transaction
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    got = pack(reset_to_rob_bus, pc_to_fetcher, value_to_reg_file, dest_to_reg_file, rd_to_reg_file);
    if (got != '0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL commit_unexpected: got 0x%0h expected no commit", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL commit_txn: got 0x%0h expected 0x%0h", got, exp);
        end
      end
    end
  end

  initial begin
    query_j_id = '0; query_k_id = '0;
    do_reset();
    check("reset_tail", 32'(dest_to_issuer), 32'd1);
    check("reset_full", 32'(full_to_issuer), 32'd0);
    check("reset_dest", 32'(dest_to_reg_file), 32'd0);
    check("reset_flush", 32'(reset_to_rob_bus), 32'd0);
    check("reset_pc", pc_to_fetcher, 32'd0);

    // Basic issue -> CDB -> commit
    issue(5'd5, 1'b0);
    exp_q.push_back(pack(1'b0, 32'd0, 32'h1234, 4'd1, 5'd5));
    cdb(4'd1, 32'h1234, 1'b0);
    tick();
    check("t1_dest", 32'(dest_to_reg_file), 32'd1);
    check("t1_rd", 32'(rd_to_reg_file), 32'd5);
    check("t1_value", value_to_reg_file, 32'h1234);
    tick();
    check("t1_dest_idle", 32'(dest_to_reg_file), 32'd0);
    check("t1_rd_idle", 32'(rd_to_reg_file), 32'd0);
    check("t1_tail", 32'(dest_to_issuer), 32'd2);

    // Fill, overflow attempt, wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_tail_seq", 32'(dest_to_issuer), 32'(i + 1));
      issue(5'(i + 1), 1'b0);
    end
    check("t2_full", 32'(full_to_issuer), 32'd1);
    check("t2_tail_wrap", 32'(dest_to_issuer), 32'd1);
    issue(5'd31, 1'b0);
    check("t2_full_ignored", 32'(full_to_issuer), 32'd1);
    check("t2_tail_ignored", 32'(dest_to_issuer), 32'd1);
    exp_q.push_back(pack(1'b0, 32'd0, 32'hA1, 4'd1, 5'd1));
    cdb(4'd1, 32'hA1, 1'b0);
    tick();
    check("t2_not_full", 32'(full_to_issuer), 32'd0);
    check("t2_new_id", 32'(dest_to_issuer), 32'd1);
    issue(5'd20, 1'b0);
    check("t2_full_again", 32'(full_to_issuer), 32'd1);
    check("t2_tail_after", 32'(dest_to_issuer), 32'd2);

    // Out-of-order completion, in-order commit
    do_reset();
    issue(5'd7, 1'b0);
    issue(5'd9, 1'b0);
    query_j_id = 4'd1;
    cdb(4'd2, 32'h22, 1'b0);
    check("t3_q1_notready", 32'(ready_j), 32'd0);
    check("t3_q1_value0", value_j, 32'd0);
    query_k_id = 4'd2;
    #1;
    check("t3_q2_ready", 32'(ready_k), 32'd1);
    check("t3_q2_value", value_k, 32'h22);
    check("t3_no_early", 32'(dest_to_reg_file), 32'd0);
    exp_q.push_back(pack(1'b0, 32'd0, 32'h11, 4'd1, 5'd7));
    exp_q.push_back(pack(1'b0, 32'd0, 32'h22, 4'd2, 5'd9));
    cdb(4'd1, 32'h11, 1'b0);
    tick();
    check("t3_first", 32'(dest_to_reg_file), 32'd1);
    tick();
    check("t3_second", 32'(dest_to_reg_file), 32'd2);
    tick();
    check("t3_idle", 32'(dest_to_reg_file), 32'd0);
    query_j_id = '0; query_k_id = '0;

    // Mispredicted branch flush; issue/CDB during the flush cycle are dropped
    do_reset();
    issue(5'd6, 1'b1);
    issue(5'd3, 1'b0);
    exp_q.push_back(pack(1'b1, 32'h80, 32'd0, 4'd0, 5'd0));
    cdb(4'd1, 32'h80, 1'b1);
    tick();
    check("t4_flush", 32'(reset_to_rob_bus), 32'd1);
    check("t4_pc", pc_to_fetcher, 32'h80);
    check("t4_no_regwrite", 32'(dest_to_reg_file), 32'd0);
    cdb_valid = 1'b1; cdb_id = 4'd2; cdb_value = 32'h33;
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    idle();
    check("t4_tail_reset", 32'(dest_to_issuer), 32'd1);
    check("t4_flush_pulse", 32'(reset_to_rob_bus), 32'd0);
    check("t4_not_full", 32'(full_to_issuer), 32'd0);
    query_j_id = 4'd2;
    #1;
    check("t4_q2_dropped", 32'(ready_j), 32'd0);
    tick();
    tick();
    check("t4_no_commit", 32'(dest_to_reg_file), 32'd0);
    query_j_id = '0;

    // Query bypass vs stored ready bits
    do_reset();
    for (int i = 1; i <= 4; i++) issue(5'(i), 1'b0);
    cdb_valid = 1'b1; cdb_id = 4'd4; cdb_value = 32'h55;
    query_j_id = 4'd4; query_k_id = 4'd0;
    #1;
`ifdef RO_BUFFER_BYPASS_EN
    check("t5_same_ready", 32'(ready_j), 32'd1);
    check("t5_same_value", value_j, 32'h55);
`else
    check("t5_same_ready", 32'(ready_j), 32'd0);
    check("t5_same_value", value_j, 32'd0);
`endif
    check("t5_id0_ready", 32'(ready_k), 32'd1);
    check("t5_id0_value", value_k, 32'd0);
    tick();
    idle();
    check("t5_next_ready", 32'(ready_j), 32'd1);
    check("t5_next_value", value_j, 32'h55);
    query_j_id = '0;

    // rdy=0 holds a ready head
    exp_q.push_back(pack(1'b0, 32'd0, 32'h66, 4'd1, 5'd1));
    cdb(4'd1, 32'h66, 1'b0);
    rdy = 1'b0;
    tick();
    tick();
    check("t6_hold", 32'(dest_to_reg_file), 32'd0);
    rdy = 1'b1;
    tick();
    check("t6_release_dest", 32'(dest_to_reg_file), 32'd1);
    check("t6_release_value", value_to_reg_file, 32'h66);

    // Reset during flush cycle
    do_reset();
    issue(5'd2, 1'b1);
    exp_q.push_back(pack(1'b1, 32'h40, 32'd0, 4'd0, 5'd0));
    cdb(4'd1, 32'h40, 1'b1);
    tick();
    check("t7_flush", 32'(reset_to_rob_bus), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7_rst_flush", 32'(reset_to_rob_bus), 32'd0);
    check("t7_rst_pc", pc_to_fetcher, 32'd0);
    check("t7_rst_tail", 32'(dest_to_issuer), 32'd1);
    check("t7_rst_full", 32'(full_to_issuer), 32'd0);
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
